// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: reads the word at the current PC over a req/ack handshake,
// latches it as the instruction register and pulses IncPC/PC_enable once per fetch.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_go,
  input  logic [31:0]           pc_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_data,
  output logic [31:0]           ir_out,
  output logic                  ir_valid,
  input  logic                  instr_ack,
  output logic                  IncPC,
  output logic                  PC_enable,
  output logic                  busy,
  output logic                  fetch_err,
  output logic [15:0]           fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [7:0]            tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [31:0]           ir_q, ir_d;
  logic                  ir_valid_q, ir_valid_d;
  logic                  inc_pc_q, inc_pc_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [15:0]           count_q, count_d;
  logic                  pc_in_range;

  assign pc_in_range = (pc_in[31:ADDR_WIDTH] == {(32-ADDR_WIDTH){1'b0}});

  // Next-state and next-output logic for the IDLE/REQ/VALID sequencer
  always_comb begin
    state_d    = state_q;
    tmo_cnt_d  = tmo_cnt_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    inc_pc_d   = 1'b0;
    err_d      = err_q;
    count_d    = count_q;

    case (state_q)
      S_IDLE: begin
        if (fetch_go) begin
          if (pc_in_range) begin
            mem_addr_d = pc_in[ADDR_WIDTH-1:0];
            mem_rd_d   = 1'b1;
            tmo_cnt_d  = 8'd0;
            state_d    = S_REQ;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          ir_d       = mem_data;
          mem_rd_d   = 1'b0;
          inc_pc_d   = 1'b1;
          ir_valid_d = 1'b1;
          count_d    = count_q + 16'd1;
          state_d    = S_VALID;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Abort: IR and its valid flag are left untouched
          mem_rd_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      S_VALID: begin
        if (instr_ack) begin
          ir_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          ir_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        mem_rd_d   = 1'b0;
        ir_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tmo_cnt_q  <= 8'd0;
      mem_addr_q <= {ADDR_WIDTH{1'b0}};
      mem_rd_q   <= 1'b0;
      ir_q       <= 32'd0;
      ir_valid_q <= 1'b0;
      inc_pc_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      inc_pc_q   <= inc_pc_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  // One flop drives both strobes so PC_enable can never appear without IncPC
  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign ir_out      = ir_q;
  assign ir_valid    = ir_valid_q;
  assign IncPC       = inc_pc_q;
  assign PC_enable   = inc_pc_q;
  assign busy        = busy_q;
  assign fetch_err   = err_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of fetch vectors plus hand-written
// sequences for timeout, mid-transaction reset, back-to-back fetches and counter wrap.
module tb_instr_fetch_unit;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset, fetch_go, mem_ack, instr_ack;
  logic [31:0]   pc_in, mem_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, ir_valid, IncPC, PC_enable, busy, fetch_err;
  logic [31:0]   ir_out;
  logic [15:0]   fetch_count;

  int tests = 0;
  int fails = 0;
  int inc_pulses = 0;
  int pair_err = 0;

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   data;
    int            ack_dly;
    int            iack_dly;
    logic          in_range;
    logic [AW-1:0] exp_addr;
    int            exp_rd;
    int            exp_vld;
    int            exp_pulses;
    logic [31:0]   exp_ir;
    logic [15:0]   exp_count;
    logic          exp_err;
  } vec_t;

  vec_t vecs[6];

  instr_fetch_unit #(.ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .fetch_go(fetch_go), .pc_in(pc_in),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
    .ir_out(ir_out), .ir_valid(ir_valid), .instr_ack(instr_ack),
    .IncPC(IncPC), .PC_enable(PC_enable), .busy(busy),
    .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // PC-side view: count increment strobes and any strobe disagreement
  always @(posedge clk) begin
    if (IncPC === 1'b1) inc_pulses <= inc_pulses + 1;
    if (IncPC !== PC_enable) pair_err <= pair_err + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; fetch_go = 1'b0; mem_ack = 1'b0; instr_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int p0;
    int rd_cyc;
    int vld_cyc;
    p0 = inc_pulses;
    pc_in = v.pc;
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    if (!v.in_range) begin
      chk("oor_mem_rd", {31'd0, mem_rd}, 32'd0);
      chk("oor_err", {31'd0, fetch_err}, 32'd1);
      chk("oor_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("oor_mem_rd_later", {31'd0, mem_rd}, 32'd0);
    end else begin
      rd_cyc = 0;
      for (int i = 0; i < v.ack_dly; i++) begin
        chk("req_addr", {23'd0, mem_addr}, {23'd0, v.exp_addr});
        if (mem_rd) rd_cyc++;
        tick();
      end
      chk("req_addr", {23'd0, mem_addr}, {23'd0, v.exp_addr});
      if (mem_rd) rd_cyc++;
      mem_ack = 1'b1;
      mem_data = v.data;
      tick();
      mem_ack = 1'b0;
      chk("rd_cycles", rd_cyc, v.exp_rd);
      chk("valid_mem_rd", {31'd0, mem_rd}, 32'd0);
      chk("valid_ir_valid", {31'd0, ir_valid}, 32'd1);
      chk("valid_incpc", {31'd0, IncPC}, 32'd1);
      chk("valid_pc_enable", {31'd0, PC_enable}, 32'd1);
      chk("valid_ir_out", ir_out, v.exp_ir);
      vld_cyc = 1;
      for (int i = 0; i < v.iack_dly; i++) begin
        tick();
        if (ir_valid) vld_cyc++;
        chk("hold_incpc", {31'd0, IncPC}, 32'd0);
      end
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      chk("vld_cycles", vld_cyc, v.exp_vld);
      chk("ack_ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("ack_busy", {31'd0, busy}, 32'd0);
    end
    chk("pulses", inc_pulses - p0, v.exp_pulses);
    chk("ir_out", ir_out, v.exp_ir);
    chk("fetch_count", {16'd0, fetch_count}, {16'd0, v.exp_count});
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, v.exp_err});
  endtask

  initial begin
    int p0;
    int n;
    int c;
    int cyc[$];
    vec_t v;

    vecs[0] = '{32'h0000_0005, 32'hA1B2_C3D4, 0, 0, 1'b1, 9'h005, 1, 1, 1, 32'hA1B2_C3D4, 16'd1, 1'b0};
    vecs[1] = '{32'h0000_0005, 32'h1122_3344, 5, 3, 1'b1, 9'h005, 6, 4, 1, 32'h1122_3344, 16'd2, 1'b0};
    vecs[2] = '{32'h0000_0200, 32'h0000_0000, 0, 0, 1'b0, 9'h000, 0, 0, 0, 32'h1122_3344, 16'd2, 1'b1};
    vecs[3] = '{32'h0000_01FF, 32'hDEAD_BEEF, 2, 1, 1'b1, 9'h1FF, 3, 2, 1, 32'hDEAD_BEEF, 16'd3, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0F0F_0F0F, 0, 0, 1'b1, 9'h000, 1, 1, 1, 32'h0F0F_0F0F, 16'd4, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 1'b0, 9'h000, 0, 0, 0, 32'h0F0F_0F0F, 16'd4, 1'b1};

    pc_in = 32'd0; mem_data = 32'd0;
    do_reset();
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_ir_out", ir_out, 32'd0);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_incpc", {31'd0, IncPC}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_count", {16'd0, fetch_count}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Timeout with mem_ack held low, then a normal fetch with the error still set
    do_reset();
    v = '{32'h0000_0007, 32'hCAFE_F00D, 0, 0, 1'b1, 9'h007, 1, 1, 1, 32'hCAFE_F00D, 16'd1, 1'b0};
    run_vec(v);
    p0 = inc_pulses;
    pc_in = 32'h0000_0008;
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    n = 0;
    while (mem_rd && n < 40) begin
      n++;
      tick();
    end
    chk("tmo_rd_cycles", n, 16);
    chk("tmo_err", {31'd0, fetch_err}, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_ir_out", ir_out, 32'hCAFE_F00D);
    chk("tmo_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("tmo_pulses", inc_pulses - p0, 0);
    v = '{32'h0000_0009, 32'h1234_5678, 1, 0, 1'b1, 9'h009, 2, 1, 1, 32'h1234_5678, 16'd2, 1'b1};
    run_vec(v);

    // Reset during the third REQ cycle, followed by a stale ack
    p0 = inc_pulses;
    pc_in = 32'h0000_0003;
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    tick();
    tick();
    chk("mid_req_rd", {31'd0, mem_rd}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_rd", {31'd0, mem_rd}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_count", {16'd0, fetch_count}, 32'd0);
    chk("mid_rst_err", {31'd0, fetch_err}, 32'd0);
    mem_ack = 1'b1;
    mem_data = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_valid", {31'd0, ir_valid}, 32'd0);
    chk("late_ack_busy", {31'd0, busy}, 32'd0);
    chk("late_ack_ir", ir_out, 32'd0);
    chk("late_ack_pulses", inc_pulses - p0, 0);

    // fetch_go, mem_ack and instr_ack all held high: one fetch every 3 cycles
    pc_in = 32'h0000_0020;
    mem_data = 32'h600D_0000;
    mem_ack = 1'b1;
    instr_ack = 1'b1;
    fetch_go = 1'b1;
    for (c = 1; c <= 12; c++) begin
      tick();
      if (IncPC) cyc.push_back(c);
    end
    fetch_go = 1'b0;
    mem_ack = 1'b0;
    instr_ack = 1'b0;
    tick();
    chk("b2b_pulse_count", cyc.size(), 4);
    if (cyc.size() > 0) chk("b2b_first_pulse", cyc[0], 2);
    for (int i = 1; i < cyc.size(); i++) chk("b2b_spacing", cyc[i] - cyc[i-1], 3);
    chk("b2b_count", {16'd0, fetch_count}, 32'd4);
    chk("b2b_busy", {31'd0, busy}, 32'd0);
    chk("b2b_ir_out", ir_out, 32'h600D_0000);

    // Counter wrap from 0xFFFF
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    tick();
    chk("wrap_preload", {16'd0, fetch_count}, 32'h0000_FFFF);
    v = '{32'h0000_0010, 32'h55AA_55AA, 0, 0, 1'b1, 9'h010, 1, 1, 1, 32'h55AA_55AA, 16'h0000, 1'b0};
    run_vec(v);

    chk("strobe_pairing", pair_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
